// File: rtl/eth_fcs_checker.sv
// eth_fcs_checker: checks Ethernet FCS, measures frame length and forwards the payload with the 4 FCS bytes stripped
module eth_fcs_checker #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_frame,
  input  logic        rx_we,
  input  logic [7:0]  rx_byte,
  output logic        out_we,
  output logic [7:0]  out_byte,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        len_err,
  output logic [10:0] frame_len
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] PASS = 2'd2;
  localparam logic [1:0] DROP = 2'd3;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  logic [1:0]  state_q, state_d;
  logic        rx_frame_prev_q;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic [31:0] dl_q, dl_d;
  logic        out_we_q, out_we_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_err_q, len_err_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic        rise, in_frame, acc;
  logic [10:0] len_inc;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ b[i]) ? POLY : 32'h0);
    return r;
  endfunction
  always_comb begin
    rise = rx_frame & ~rx_frame_prev_q;
    in_frame = state_q != IDLE;
    acc = rx_we & rx_frame & (in_frame | rise);
    len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    state_d = state_q;
    crc_d = crc_q;
    len_d = len_q;
    dl_d = dl_q;
    out_we_d = 1'b0;
    out_byte_d = out_byte_q;
    out_sof_d = 1'b0;
    out_eof_d = 1'b0;
    frame_done_d = 1'b0;
    crc_ok_d = crc_ok_q;
    len_err_d = len_err_q;
    frame_len_d = frame_len_q;
    if (in_frame && !rx_frame) begin
      crc_ok_d = crc_q == RESIDUE;
      len_err_d = (len_q < MIN_L) || (len_q > MAX_L);
      frame_len_d = len_q;
      frame_done_d = 1'b1;
      out_eof_d = 1'b1;
      crc_d = '1;
      len_d = '0;
      dl_d = '0;
      state_d = IDLE;
    end else begin
      if (rise && !in_frame) state_d = FILL;
      if (acc) begin
        crc_d = crc_byte(crc_q, rx_byte);
        len_d = len_inc;
        dl_d = {dl_q[23:0], rx_byte};
        if (len_inc > MAX_L) state_d = DROP;
        else if (state_q == PASS) begin
          out_we_d = 1'b1;
          out_byte_d = dl_q[31:24];
          out_sof_d = len_inc == 11'd5;
        end else if (len_inc == 11'd4) state_d = PASS;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rx_frame_prev_q <= 1'b1;
      crc_q <= '1;
      len_q <= '0;
      dl_q <= '0;
      out_we_q <= 1'b0;
      out_byte_q <= '0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
      frame_done_q <= 1'b0;
      crc_ok_q <= 1'b0;
      len_err_q <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q <= state_d;
      rx_frame_prev_q <= rx_frame;
      crc_q <= crc_d;
      len_q <= len_d;
      dl_q <= dl_d;
      out_we_q <= out_we_d;
      out_byte_q <= out_byte_d;
      out_sof_q <= out_sof_d;
      out_eof_q <= out_eof_d;
      frame_done_q <= frame_done_d;
      crc_ok_q <= crc_ok_d;
      len_err_q <= len_err_d;
      frame_len_q <= frame_len_d;
    end
  end
  assign out_we = out_we_q;
  assign out_byte = out_byte_q;
  assign out_sof = out_sof_q;
  assign out_eof = out_eof_q;
  assign frame_done = frame_done_q;
  assign crc_ok = crc_ok_q;
  assign len_err = len_err_q;
  assign frame_len = frame_len_q;
endmodule
